hex_seg_decoder: RTL and testbench

- Monitors a scanned, multiplexed active-low 7-segment display bus (segment lines plus one-hot digit select) and recovers the hex nibble shown on each digit.
- Only display-side protocol decoder in the design: reads back what the 7-segment encoder path drives.
- Used for self-check and FPGA-side readback of displayed values.
- Filters scan glitches with a per-sample stability counter; flags illegal segment patterns per digit.

---
 rtl/hex_seg_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_hex_seg_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder
// Purpose:
//   Reads back a scanned, multiplexed, active-low 7-segment display bus and
//   recovers the hex nibble shown on each digit. Each {segments, select}
//   sample must stay identical for STABLE_CYCLES consecutive cycles before
//   it is committed, which filters out ghosting and glitches at scan edges.
//   A committed pattern that is neither a hex glyph nor blank sets the
//   digit's error flag.
// Parameters:
//   NUM_DIGITS    - number of scanned digits (1..8)
//   STABLE_CYCLES - identical consecutive samples required to commit (>=2)
// Ports:
//   Clk     - system clock, rising edge
//   Reset   - synchronous, active-high reset
//   Seg_In  - active-low segment lines, bit0=a .. bit6=g
//   Dig_Sel - active-high one-hot digit select from the display scanner
//   Hex_Out - recovered nibbles, digit d at [4d+3:4d]
//   Valid   - digit d holds a legally decoded nibble
//   Err     - the last pattern committed on digit d was illegal
//   Update  - one-cycle pulse on each commit
//   Upd_Idx - digit index of the commit, zero while Update is low
// Build option:
//   HEX_SEG_DECODER_CHANGE_ONLY_EN - when defined, Update pulses only if a
//   commit changes the stored {nibble, Valid, Err} of the digit.
module hex_seg_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [6:0]              Seg_In,
  input  logic [NUM_DIGITS-1:0]   Dig_Sel,
  output logic [4*NUM_DIGITS-1:0] Hex_Out,
  output logic [NUM_DIGITS-1:0]   Valid,
  output logic [NUM_DIGITS-1:0]   Err,
  output logic                    Update,
  output logic [2:0]              Upd_Idx
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, TRACK, COMMIT, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [6:0]              seg_q, prevSeg_q;
  logic [NUM_DIGITS-1:0]   sel_q, prevSel_q;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    update_q, update_d;
  logic [2:0]              updIdx_q, updIdx_d;

  logic                    legalSel;
  logic [2:0]              selIdx;
  logic                    changed;
  logic                    commit;
  logic [3:0]              decNib;
  logic                    decLegal;
  logic                    decBlank;
`ifdef HEX_SEG_DECODER_CHANGE_ONLY_EN
  logic                    differs;
`endif

  // Select legality and the index of the selected digit.
  always_comb begin
    int ones;
    ones   = 0;
    selIdx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) begin
        ones   = ones + 1;
        selIdx = 3'(i);
      end
    end
    legalSel = (ones == 1);
  end

  assign changed = ({seg_q, sel_q} != {prevSeg_q, prevSel_q});

  // Glyph table: active-low segment pattern to nibble.
  always_comb begin
    decNib   = 4'h0;
    decLegal = 1'b1;
    decBlank = (seg_q == 7'h7F);
    case (seg_q)
      7'h40: decNib = 4'h0;
      7'h79: decNib = 4'h1;
      7'h24: decNib = 4'h2;
      7'h30: decNib = 4'h3;
      7'h19: decNib = 4'h4;
      7'h12: decNib = 4'h5;
      7'h02: decNib = 4'h6;
      7'h78: decNib = 4'h7;
      7'h00: decNib = 4'h8;
      7'h10: decNib = 4'h9;
      7'h08: decNib = 4'hA;
      7'h03: decNib = 4'hB;
      7'h46: decNib = 4'hC;
      7'h21: decNib = 4'hD;
      7'h06: decNib = 4'hE;
      7'h0E: decNib = 4'hF;
      default: decLegal = 1'b0;
    endcase
  end

  // The counter after an edge reflects samples up to the previous edge, so
  // the commit decision is taken when the counter is one short of the
  // target and the current sample still matches; outputs and Update then
  // change on the same edge the counter saturates.
  // A change seen during the COMMIT cycle restarts tracking immediately;
  // otherwise HOLD would adopt the new sample as its reference and never
  // commit it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!legalSel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = TRACK;
          cnt_d   = CNT_ONE;
        end
        TRACK: begin
          if (changed) begin
            cnt_d = CNT_ONE;
          end else if (cnt_q >= CNT_LAST) begin
            cnt_d   = CNT_MAX;
            state_d = COMMIT;
            commit  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        COMMIT, HOLD: begin
          if (changed) begin
            state_d = TRACK;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Per-digit storage update; only the selected digit is touched.
  always_comb begin
    hex_d   = hex_q;
    valid_d = valid_q;
    err_d   = err_q;
`ifdef HEX_SEG_DECODER_CHANGE_ONLY_EN
    differs = 1'b0;
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (commit && sel_q[d]) begin
        if (decLegal) begin
          hex_d[4*d +: 4] = decNib;
        end
        valid_d[d] = decLegal;
        err_d[d]   = !decLegal && !decBlank;
`ifdef HEX_SEG_DECODER_CHANGE_ONLY_EN
        differs = (hex_d[4*d +: 4] != hex_q[4*d +: 4]) ||
                  (valid_d[d] != valid_q[d]) || (err_d[d] != err_q[d]);
`endif
      end
    end
`ifdef HEX_SEG_DECODER_CHANGE_ONLY_EN
    update_d = commit && differs;
`else
    update_d = commit;
`endif
    updIdx_d = update_d ? selIdx : 3'd0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seg_q     <= '0;
      sel_q     <= '0;
      prevSeg_q <= '0;
      prevSel_q <= '0;
      hex_q     <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      update_q  <= 1'b0;
      updIdx_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seg_q     <= Seg_In;
      sel_q     <= Dig_Sel;
      prevSeg_q <= seg_q;
      prevSel_q <= sel_q;
      hex_q     <= hex_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      update_q  <= update_d;
      updIdx_q  <= updIdx_d;
    end
  end

  assign Hex_Out = hex_q;
  assign Valid   = valid_q;
  assign Err     = err_q;
  assign Update  = update_q;
  assign Upd_Idx = updIdx_q;

endmodule

// File: tb/tb_hex_seg_decoder.sv
// tb_hex_seg_decoder
// Directed bench for hex_seg_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// The stimulus sequence pushes each expected commit into a queue; a monitor
// pops and compares on every Update pulse.
module tb_hex_seg_decoder;

  logic        clock;
  logic        reset;
  logic [6:0]  segIn;
  logic [3:0]  digSel;
  logic [15:0] hexOut;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        update;
  logic [2:0]  updIdx;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] hex;
    logic [3:0]  valid;
    logic [3:0]  err;
  } exp_t;

  exp_t        expQ[$];
  int          compared;
  int          mismatched;
  int          updCount;
  logic [15:0] mHex;
  logic [3:0]  mValid;
  logic [3:0]  mErr;
  int          base;

  hex_seg_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .Clk(clock),
    .Reset(reset),
    .Seg_In(segIn),
    .Dig_Sel(digSel),
    .Hex_Out(hexOut),
    .Valid(valid),
    .Err(err),
    .Update(update),
    .Upd_Idx(updIdx)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Record an expected commit; with the change-only option a commit that
  // leaves the digit unchanged produces no Update pulse.
  task automatic expectCommit(input logic [2:0] idx, input logic [15:0] hex,
                              input logic [3:0] v, input logic [3:0] e);
    exp_t item;
    item.idx   = idx;
    item.hex   = hex;
    item.valid = v;
    item.err   = e;
`ifdef HEX_SEG_DECODER_CHANGE_ONLY_EN
    if (hex != mHex || v != mValid || e != mErr) expQ.push_back(item);
`else
    expQ.push_back(item);
`endif
    mHex   = hex;
    mValid = v;
    mErr   = e;
  endtask

  // Inputs change 2 units after a rising edge; direct checks happen there too.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] sel, input int n);
    segIn  = seg;
    digSel = sel;
    waitCycles(n);
  endtask

  // Monitor: pops the scoreboard on each Update pulse.
  always @(negedge clock) begin
    if (update) begin
      updCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected update idx", {29'd0, updIdx}, 32'hFFFF_FFFF);
      end else begin
        exp_t item;
        item = expQ.pop_front();
        checkOutput("commit idx", {29'd0, updIdx}, {29'd0, item.idx});
        checkOutput("commit hex", {16'd0, hexOut}, {16'd0, item.hex});
        checkOutput("commit valid", {28'd0, valid}, {28'd0, item.valid});
        checkOutput("commit err", {28'd0, err}, {28'd0, item.err});
      end
    end else begin
      checkOutput("idle upd_idx", {29'd0, updIdx}, 32'd0);
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    updCount   = 0;
    mHex       = 16'h0;
    mValid     = 4'h0;
    mErr       = 4'h0;
    reset      = 1'b1;
    segIn      = 7'h79;
    digSel     = 4'b0001;

    // Reset with a live bus, then latency of the first commit.
    waitCycles(2);
    checkOutput("reset hex", {16'd0, hexOut}, 32'd0);
    checkOutput("reset valid", {28'd0, valid}, 32'd0);
    checkOutput("reset err", {28'd0, err}, 32'd0);
    checkOutput("reset update", {31'd0, update}, 32'd0);
    checkOutput("reset upd_idx", {29'd0, updIdx}, 32'd0);
    expectCommit(3'd0, 16'h0001, 4'b0001, 4'b0000);
    reset = 1'b0;
    waitCycles(4);
    checkOutput("no update before 5th edge", {31'd0, update}, 32'd0);
    waitCycles(1);
    checkOutput("update at 5th edge", {31'd0, update}, 32'd1);
    checkOutput("digit0 nibble after first commit", {28'd0, hexOut[3:0]}, 32'd1);
    waitCycles(1);
    checkOutput("update is one cycle", {31'd0, update}, 32'd0);

    // Full scan of four digits.
    base = updCount;
    expectCommit(3'd0, 16'h0000, 4'b0001, 4'b0000);
    applyStimulus(7'h40, 4'b0001, 6);
    expectCommit(3'd1, 16'h0020, 4'b0011, 4'b0000);
    applyStimulus(7'h24, 4'b0010, 6);
    expectCommit(3'd2, 16'h0F20, 4'b0111, 4'b0000);
    applyStimulus(7'h0E, 4'b0100, 6);
    expectCommit(3'd3, 16'hDF20, 4'b1111, 4'b0000);
    applyStimulus(7'h21, 4'b1000, 6);
    checkOutput("scan hex", {16'd0, hexOut}, 32'hDF20);
    checkOutput("scan valid", {28'd0, valid}, 32'hF);
    checkOutput("scan update count", updCount - base, 32'd4);

    // Three stable cycles are not enough; four are.
    base = updCount;
    applyStimulus(7'h12, 4'b0100, 3);
    expectCommit(3'd2, 16'hD320, 4'b1111, 4'b0000);
    applyStimulus(7'h30, 4'b0100, 4);

    // Illegal selects: no commits, storage untouched.
    applyStimulus(7'h40, 4'b0110, 10);
    applyStimulus(7'h40, 4'b0000, 10);
    checkOutput("short-glitch update count", updCount - base, 32'd1);
    checkOutput("hex after illegal select", {16'd0, hexOut}, 32'hD320);

    // Blank clears Valid, keeps the nibble.
    expectCommit(3'd2, 16'hD320, 4'b1011, 4'b0000);
    applyStimulus(7'h7F, 4'b0100, 6);
    checkOutput("blank valid", {28'd0, valid}, 32'hB);

    // Illegal glyph, then a legal one on the same digit.
    expectCommit(3'd1, 16'hD320, 4'b1001, 4'b0010);
    applyStimulus(7'h7E, 4'b0010, 6);
    checkOutput("illegal err", {28'd0, err}, 32'h2);
    expectCommit(3'd1, 16'hD380, 4'b1011, 4'b0000);
    applyStimulus(7'h00, 4'b0010, 6);
    checkOutput("recovered hex", {16'd0, hexOut}, 32'hD380);

    // Two identical scan passes.
    base = updCount;
    for (int pass = 0; pass < 2; pass++) begin
      expectCommit(3'd0, (pass == 0) ? 16'hD380 : 16'hDF20, (pass == 0) ? 4'b1011 : 4'b1111, 4'b0000);
      applyStimulus(7'h40, 4'b0001, 6);
      expectCommit(3'd1, (pass == 0) ? 16'hD320 : 16'hDF20, (pass == 0) ? 4'b1011 : 4'b1111, 4'b0000);
      applyStimulus(7'h24, 4'b0010, 6);
      expectCommit(3'd2, 16'hDF20, 4'b1111, 4'b0000);
      applyStimulus(7'h0E, 4'b0100, 6);
      expectCommit(3'd3, 16'hDF20, 4'b1111, 4'b0000);
      applyStimulus(7'h21, 4'b1000, 6);
    end
`ifdef HEX_SEG_DECODER_CHANGE_ONLY_EN
    checkOutput("double scan update count", updCount - base, 32'd2);
`else
    checkOutput("double scan update count", updCount - base, 32'd8);
`endif

    // Reset while tracking discards the pending sample.
    base = updCount;
    applyStimulus(7'h79, 4'b0010, 2);
    reset = 1'b1;
    waitCycles(2);
    reset  = 1'b0;
    digSel = 4'b0000;
    waitCycles(8);
    checkOutput("post-reset hex", {16'd0, hexOut}, 32'd0);
    checkOutput("post-reset valid", {28'd0, valid}, 32'd0);
    checkOutput("post-reset err", {28'd0, err}, 32'd0);
    checkOutput("reset-in-track update count", updCount - base, 32'd0);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
